otn_deframer: RTL
=================

OTN_DEFRAMER -- requirements
Module: otn_deframer

Interface
REQ-001 SHALL have parameter PYLD_LEN, default 16, payload bytes per frame (range 1-255).
REQ-002 SHALL have parameter ACK_CYCLES, default 16, width of the ACK high pulse in i_clk cycles.
REQ-003 SHALL have parameter TIMEOUT, default 4096, maximum idle cycles between bytes inside a frame.
REQ-004 i_clk  in  1  system clock; all logic is on the rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_byte  in  8  received line byte from the upstream UART receiver.
REQ-007 i_byte_valid  in  1  single-cycle strobe qualifying i_byte.
REQ-008 i_arq_en  in  1  ACK generation enable switch.
REQ-009 o_pyld_data  out  8  extracted payload byte.
REQ-010 o_pyld_valid  out  1  strobe qualifying o_pyld_data.
REQ-011 o_pyld_sof / o_pyld_eof  out  1 each  asserted with the first / last payload byte of a frame.
REQ-012 o_frame_good / o_frame_bad  out  1 each  single-cycle frame verdict pulses.
REQ-013 o_crc_val  out  8  CRC computed over the last completed frame.
REQ-014 o_state  out  3  FSM state: HUNT=0, FAS2=1, PYLD=2, CRC=3.
REQ-015 o_otn_tx_ack  out  1  ACK line back to the sender.

Function
REQ-016 Frame format SHALL be FAS 0xF6, FAS 0x28, PYLD_LEN payload bytes, then 1 CRC byte; bytes are consumed only on i_byte_valid.
REQ-017 HUNT: byte 0xF6 -> FAS2; any other byte -> stay in HUNT.
REQ-018 FAS2: 0x28 -> PYLD, with the payload counter and the CRC register cleared to 0; 0xF6 -> stay in FAS2; any other byte -> HUNT.
REQ-019 PYLD: each byte SHALL be forwarded on o_pyld_data/o_pyld_valid, registered exactly 1 cycle after i_byte_valid; SOF on count 0, EOF on count PYLD_LEN-1; after the last byte -> CRC.
REQ-020 CRC SHALL be CRC-8, polynomial 0x07, init 0x00, MSB first, no reflection, no final XOR, computed over payload bytes only and updated one byte per accepted byte.
REQ-021 CRC state: the received byte SHALL be compared with the computed CRC; match -> o_frame_good, mismatch -> o_frame_bad; either pulse occurs 1 cycle after the CRC byte is accepted, o_crc_val latches the computed CRC in the same cycle, and the FSM returns to HUNT.
REQ-022 Payload SHALL be delivered before the verdict; downstream discards the frame on o_frame_bad.
REQ-023 In FAS2, PYLD and CRC, an idle counter SHALL reset on each accepted byte; on reaching TIMEOUT the FSM SHALL go to HUNT, pulse o_frame_bad, and emit no o_pyld_eof.
REQ-024 On o_frame_good with i_arq_en=1, o_otn_tx_ack SHALL go high the next cycle for exactly ACK_CYCLES cycles; a new good frame during an ACK SHALL reload the counter to a full ACK_CYCLES.
REQ-025 With i_arq_en=0, o_otn_tx_ack SHALL stay 0; deassertion mid-pulse SHALL drop the ACK in the next cycle; verdict pulses are unaffected by i_arq_en.
REQ-026 A bad frame SHALL never generate an ACK; the sender's retransmit timeout handles a NAK.

Reset
REQ-027 i_rst SHALL force HUNT, clear the counters, CRC, and o_crc_val to 0x00, and drive every output to 0, including mid-frame and mid-ACK.
REQ-028 After reset, the first accepted byte SHALL be evaluated in HUNT on the cycle following the deassertion of i_rst.

Configuration
REQ-029 Macro OTN_DEFRAMER_CRC_EN defined: CRC checked per REQ-020/021.
REQ-030 Macro OTN_DEFRAMER_CRC_EN undefined: the CRC byte is still consumed and o_crc_val holds 0x00; every frame that reaches the CRC state yields o_frame_good; timeouts still yield o_frame_bad.

Verification
REQ-031 PYLD_LEN=16, bytes F6 28, 16x00, 00 -> 16 pyld strobes with SOF on the 1st and EOF on the 16th, then o_frame_good, o_crc_val=0x00, ACK high for 16 cycles.
REQ-032 PYLD_LEN=1, bytes F6 28 01 07 -> o_frame_good with o_crc_val=0x07; the same frame with a CRC byte of 0x08 -> o_frame_bad and no ACK.
REQ-033 Bytes 55 F6 F6 28 followed by a valid frame body -> 55 ignored, lock achieved on the second F6, o_frame_good.
REQ-034 A frame stalled TIMEOUT cycles after its 5th payload byte -> o_frame_bad, o_state=0, no EOF.
REQ-035 Second good frame verdict arriving 5 cycles into an ACK -> ACK remains continuously high for 5+16 cycles total; i_arq_en=0 -> ACK stays 0.
REQ-036 i_rst asserted mid-payload -> all outputs 0 the next cycle; a following clean frame -> o_frame_good.

Source files
------------

// File: rtl/otn_deframer.sv
// OTN-style byte deframer: FAS hunt, payload extraction, CRC-8 verdict, ACK pulse.
// Optional macro OTN_DEFRAMER_CRC_EN enables the CRC-8 check (else every full frame is good).
module otn_deframer #(
    parameter int PYLD_LEN   = 16,
    parameter int ACK_CYCLES = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    input  logic       i_arq_en,
    output logic [7:0] o_pyld_data,
    output logic       o_pyld_valid,
    output logic       o_pyld_sof,
    output logic       o_pyld_eof,
    output logic       o_frame_good,
    output logic       o_frame_bad,
    output logic [7:0] o_crc_val,
    output logic [2:0] o_state,
    output logic       o_otn_tx_ack
);

    localparam int CW = $clog2(PYLD_LEN + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(ACK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_FAS2 = 3'd1,
        S_PYLD = 3'd2,
        S_CRC  = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [AW-1:0]   ack_q, ack_d;
    logic [7:0]      data_q, data_d;
    logic            pv_q, pv_d;
    logic            sof_q, sof_d;
    logic            eof_q, eof_d;
    logic            good_q, good_d;
    logic            bad_q, bad_d;
    logic [7:0]      crcv_q, crcv_d;
`ifdef OTN_DEFRAMER_CRC_EN
    logic [7:0]      crc_q, crc_d;

    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_HUNT;
            cnt_q   <= '0;
            idle_q  <= '0;
            ack_q   <= '0;
            data_q  <= 8'h00;
            pv_q    <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            crcv_q  <= 8'h00;
`ifdef OTN_DEFRAMER_CRC_EN
            crc_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            pv_q    <= pv_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            crcv_q  <= crcv_d;
`ifdef OTN_DEFRAMER_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        data_d  = data_q;
        pv_d    = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        crcv_d  = crcv_q;
`ifdef OTN_DEFRAMER_CRC_EN
        crc_d   = crc_q;
`endif
        if (state_q != S_HUNT) begin
            idle_d = i_byte_valid ? '0 : idle_q + IW'(1);
        end
        unique case (state_q)
            S_HUNT: begin
                idle_d = '0;
                if (i_byte_valid && i_byte == 8'hF6) begin
                    state_d = S_FAS2;
                end
            end
            S_FAS2: begin
                if (i_byte_valid) begin
                    if (i_byte == 8'h28) begin
                        state_d = S_PYLD;
                        cnt_d   = '0;
`ifdef OTN_DEFRAMER_CRC_EN
                        crc_d   = 8'h00;
`endif
                    end else if (i_byte != 8'hF6) begin
                        state_d = S_HUNT;
                    end
                end
            end
            S_PYLD: begin
                if (i_byte_valid) begin
                    pv_d   = 1'b1;
                    data_d = i_byte;
                    sof_d  = (cnt_q == '0);
                    eof_d  = (cnt_q == CW'(PYLD_LEN - 1));
`ifdef OTN_DEFRAMER_CRC_EN
                    crc_d  = crc8_upd(crc_q, i_byte);
`endif
                    if (cnt_q == CW'(PYLD_LEN - 1)) begin
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_CRC: begin
                if (i_byte_valid) begin
                    state_d = S_HUNT;
`ifdef OTN_DEFRAMER_CRC_EN
                    crcv_d  = crc_q;
                    good_d  = (i_byte == crc_q);
                    bad_d   = (i_byte != crc_q);
`else
                    crcv_d  = 8'h00;
                    good_d  = 1'b1;
`endif
                end
            end
            default: state_d = S_HUNT;
        endcase
        // An idle line inside a frame abandons it; EOF is never emitted here.
        if (state_q != S_HUNT && !i_byte_valid && idle_q == IW'(TIMEOUT - 1)) begin
            state_d = S_HUNT;
            idle_d  = '0;
            bad_d   = 1'b1;
        end
    end

    always_comb begin
        ack_d = ack_q;
        if (!i_arq_en) begin
            ack_d = '0;
        end else if (good_q) begin
            ack_d = AW'(ACK_CYCLES);
        end else if (ack_q != '0) begin
            ack_d = ack_q - AW'(1);
        end
    end

    assign o_pyld_data  = data_q;
    assign o_pyld_valid = pv_q;
    assign o_pyld_sof   = sof_q;
    assign o_pyld_eof   = eof_q;
    assign o_frame_good = good_q;
    assign o_frame_bad  = bad_q;
    assign o_crc_val    = crcv_q;
    assign o_state      = state_q;
    assign o_otn_tx_ack = (ack_q != '0);

endmodule
